store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of queue entries; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter DATA_W, default 32, the memory data width; it SHALL be 32 or 64. BE_W = DATA_W/8.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  in  1  a MEM-stage store request is present.
REQ-006 SHALL have port in_ready  out  1  the queue can accept a request this cycle.
REQ-007 SHALL have port in_op  in  6  MIPS opcode of the request.
REQ-008 SHALL have port in_addr  in  32  byte address of the request.
REQ-009 SHALL have port in_wdata  in  DATA_W  rt value, unshifted.
REQ-010 SHALL have port exc_ades  out  1  one-cycle pulse reporting a misaligned store.
REQ-011 SHALL have port exc_badvaddr  out  32  the faulting address, valid while exc_ades=1.
REQ-012 SHALL have port mem_en  out  1  the queue head is presented to the SRAM.
REQ-013 SHALL have port mem_wen  out  BE_W  byte enables of the head entry.
REQ-014 SHALL have port mem_addr  out  32  head address, aligned to DATA_W.
REQ-015 SHALL have port mem_wdata  out  DATA_W  lane-replicated or shifted head data.
REQ-016 SHALL have port mem_ready  in  1  the SRAM accepts the head this cycle.
REQ-017 SHALL have ports empty  out  1, full  out  1, and count  out  clog2(DEPTH+1), reporting queue status.

Function
REQ-018 SHALL treat only SW, SH and SB (plus SWL/SWR when enabled) as stores; any other in_op SHALL be ignored: no enqueue, no exception.
REQ-019 SHALL drive in_ready = !full combinationally; a push SHALL occur only when in_valid & in_ready, the op is a store, and the address is aligned.
REQ-020 Alignment: SW requires DATA_W=32 and addr[1:0]=0 (or addr[2:0]=0 when DATA_W=64); SH requires addr[0]=0; SB is always aligned.
REQ-021 SHALL NOT enqueue a misaligned store; instead it SHALL assert exc_ades for exactly the next cycle with exc_badvaddr = in_addr.
REQ-022 Lane encoding uses L = addr[log2(BE_W)-1:0]. SB: wen = 1<<L, data = in_wdata[7:0] replicated BE_W times. SH: wen = 2'b11<<L, data = in_wdata[15:0] replicated. SW: wen = all ones, data = in_wdata.
REQ-023 The entry stored SHALL be the encoded {addr aligned, wen, data}; encoding happens before the queue.
REQ-024 mem_en SHALL equal !empty; mem_wen, mem_addr and mem_wdata SHALL come from the head entry and be zero when empty.
REQ-025 SHALL pop the head on mem_en & mem_ready; entries SHALL drain strictly in FIFO order.
REQ-026 Latency: an entry pushed in cycle N SHALL be presented no earlier than cycle N+1; there SHALL be no bypass while empty.
REQ-027 A simultaneous push and pop SHALL leave count unchanged; count SHALL be incremented on push-only and decremented on pop-only.
REQ-028 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-029 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH.

Reset
REQ-030 On rst=1 at a clock edge: pointers=0, count=0, empty=1, full=0, exc_ades=0, exc_badvaddr=0, and mem_en=0 next cycle.
REQ-031 Reset mid-drain SHALL discard all entries; an in-flight mem_ready in the reset cycle SHALL be ignored.

Configuration
REQ-032 With macro STORE_SWLR_EN defined, SHALL support SWL (101010) and SWR (101110) as always-aligned stores, little-endian, DATA_W=32 only, with k = addr[1:0]:
- SWL: wen = (2<<k)-1, data = in_wdata >> 8*(3-k).
- SWR: wen = 4'b1111<<k, data = in_wdata << 8*k.
REQ-033 Without STORE_SWLR_EN, SWL and SWR SHALL be ignored as non-stores.

Structure
REQ-034 Opcode constants (SW, SH, SB, SWL, SWR) and byte-enable width helpers SHALL live in the shared defines package.
REQ-035 Lane/alignment encoding SHALL be a combinational sub-module store_lane_enc; store_buffer SHALL own the queue and the exception register.

Verification
REQ-036 SB addr 0x1003, data 0x000000AB, mem_ready=1 -> next cycle mem_en=1, wen=1000, wdata=0xABABABAB, addr=0x1000.
REQ-037 SH addr 0x2001 -> next cycle exc_ades=1, badvaddr=0x2001; count stays 0; mem_en stays 0.
REQ-038 Push 4 SW with mem_ready=0 -> full=1, in_ready=0; a 5th request is not accepted; raise mem_ready -> four pops in order, then empty=1.
REQ-039 At count=2, push and pop in the same cycle -> count remains 2 and order is preserved.
REQ-040 With STORE_SWLR_EN, SWL addr 0x11, data 0xAABBCCDD -> wen=0011, wdata[15:0]=0xAABB; SWR addr 0x11 -> wen=1110, wdata[31:8]=0xBBCCDD.
REQ-041 Assert rst with 3 entries queued -> next cycle empty=1, mem_en=0, count=0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared definitions for the MEM-stage store buffer.
//   store_op_e  : MIPS store opcodes recognised by the lane encoder.
//   be_width()  : byte-enable width for a given data width.
//   lane_bits() : number of address bits that select a byte lane.
package store_buffer_pkg;

  typedef enum logic [5:0] {
    OP_SB  = 6'b101000,
    OP_SH  = 6'b101001,
    OP_SWL = 6'b101010,
    OP_SW  = 6'b101011,
    OP_SWR = 6'b101110
  } store_op_e;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: request, exception, SRAM and status signals of the store
// buffer.
//   slave  : the store buffer side (consumes requests, produces SRAM writes).
//   master : the pipeline/SRAM side driving requests and mem_ready.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int BE_W = be_width(DATA_W);
  localparam int CW   = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [31:0]       in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              exc_ades;
  logic [31:0]       exc_badvaddr;
  logic              mem_en;
  logic [BE_W-1:0]   mem_wen;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              empty;
  logic              full;
  logic [CW-1:0]     count;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, mem_ready,
    output in_ready, exc_ades, exc_badvaddr, mem_en, mem_wen, mem_addr,
           mem_wdata, empty, full, count
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata, mem_ready,
    input  in_ready, exc_ades, exc_badvaddr, mem_en, mem_wen, mem_addr,
           mem_wdata, empty, full, count
  );
endinterface

// File: rtl/store_lane_enc.sv
// store_lane_enc: combinational store decode and byte-lane encoding.
//   in : op (opcode), addr (byte address), wdata (unshifted rt value)
//   out: is_store, aligned, wen (byte enables), addr_al (word-aligned
//        address), data (lane-replicated or shifted write data)
// Optional feature: define STORE_SWLR_EN to accept SWL/SWR (DATA_W=32 only);
// otherwise those opcodes decode as non-stores.
module store_lane_enc
  import store_buffer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]               op,
  input  logic [31:0]              addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     is_store,
  output logic                     aligned,
  output logic [be_width(DATA_W)-1:0] wen,
  output logic [31:0]              addr_al,
  output logic [DATA_W-1:0]        data
);
  localparam int BE_W = be_width(DATA_W);
  localparam int LW   = lane_bits(DATA_W);

  logic [LW-1:0] lane;

  assign lane    = addr[LW-1:0];
  assign addr_al = {addr[31:LW], {LW{1'b0}}};

  always_comb begin
    is_store = 1'b0;
    aligned  = 1'b1;
    wen      = '0;
    data     = '0;
    case (op)
      OP_SB: begin
        is_store = 1'b1;
        wen      = BE_W'(1) << lane;
        data     = {BE_W{wdata[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1;
        aligned  = ~addr[0];
        wen      = BE_W'(3) << lane;
        data     = {(BE_W/2){wdata[15:0]}};
      end
      OP_SW: begin
        is_store = 1'b1;
        aligned  = (lane == '0);
        wen      = '1;
        data     = wdata;
      end
`ifdef STORE_SWLR_EN
      // Unaligned-word halves: SWL fills the low lanes up to k with the
      // high bytes of rt, SWR fills lanes k and above with the low bytes.
      OP_SWL: begin
        is_store = 1'b1;
        case (addr[1:0])
          2'd0:    begin wen = BE_W'(4'b0001); data = DATA_W'({24'b0, wdata[31:24]}); end
          2'd1:    begin wen = BE_W'(4'b0011); data = DATA_W'({16'b0, wdata[31:16]}); end
          2'd2:    begin wen = BE_W'(4'b0111); data = DATA_W'({8'b0,  wdata[31:8]});  end
          default: begin wen = BE_W'(4'b1111); data = DATA_W'(wdata[31:0]);         end
        endcase
      end
      OP_SWR: begin
        is_store = 1'b1;
        case (addr[1:0])
          2'd0:    begin wen = BE_W'(4'b1111); data = DATA_W'(wdata[31:0]);          end
          2'd1:    begin wen = BE_W'(4'b1110); data = DATA_W'({wdata[23:0], 8'b0});  end
          2'd2:    begin wen = BE_W'(4'b1100); data = DATA_W'({wdata[15:0], 16'b0}); end
          default: begin wen = BE_W'(4'b1000); data = DATA_W'({wdata[7:0],  24'b0}); end
        endcase
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: MEM-stage store queue feeding a single-port SRAM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : store_buffer_if.slave -- request handshake (in_*), address
//              error pulse (exc_*), SRAM head presentation (mem_*) and
//              queue status (empty/full/count)
// Stores are lane-encoded by store_lane_enc before entering a DEPTH-entry
// FIFO; the head is presented whenever the queue is non-empty and popped on
// mem_ready. Misaligned stores are dropped and reported one cycle later.
// Optional feature: STORE_SWLR_EN (SWL/SWR support, handled in the encoder).
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave bus
);
  localparam int BE_W = be_width(DATA_W);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);

  logic              enc_store;
  logic              enc_aligned;
  logic [BE_W-1:0]   enc_wen;
  logic [31:0]       enc_addr;
  logic [DATA_W-1:0] enc_data;

  store_lane_enc #(.DATA_W(DATA_W)) u_enc (
    .op       (bus.in_op),
    .addr     (bus.in_addr),
    .wdata    (bus.in_wdata),
    .is_store (enc_store),
    .aligned  (enc_aligned),
    .wen      (enc_wen),
    .addr_al  (enc_addr),
    .data     (enc_data)
  );

  logic [31:0]       q_addr [DEPTH];
  logic [BE_W-1:0]   q_wen  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count_q;
  logic          exc_vld_p1;
  logic [31:0]   exc_addr_p1;

  logic full_w;
  logic empty_w;
  logic accept;
  logic push;
  logic misalign;
  logic pop;

  // in_ready depends only on occupancy, so a same-cycle pop never frees a
  // slot for the incoming request.
  assign full_w   = (count_q == CW'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign accept   = bus.in_valid & ~full_w & enc_store;
  assign push     = accept & enc_aligned;
  assign misalign = accept & ~enc_aligned;
  assign pop      = ~empty_w & bus.mem_ready;

  // Stage p0 -> p1: queue control and exception register
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      exc_vld_p1  <= 1'b0;
      exc_addr_p1 <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
      exc_vld_p1  <= misalign;
      exc_addr_p1 <= misalign ? bus.in_addr : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wptr] <= enc_addr;
      q_wen[wptr]  <= enc_wen;
      q_data[wptr] <= enc_data;
    end
  end

  assign bus.in_ready     = ~full_w;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.count        = count_q;
  assign bus.exc_ades     = exc_vld_p1;
  assign bus.exc_badvaddr = exc_addr_p1;
  assign bus.mem_en       = ~empty_w;
  assign bus.mem_wen      = empty_w ? '0 : q_wen[rptr];
  assign bus.mem_addr     = empty_w ? '0 : q_addr[rptr];
  assign bus.mem_wdata    = empty_w ? '0 : q_data[rptr];

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized bench for store_buffer with a
// queue-based reference model of the store encoding and FIFO behaviour.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb_if)
  );

  ent_t        mq[$];
  bit          m_exc;
  logic [31:0] m_bad;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding written from the byte-lane rules.
  function automatic void model_enc(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] w, output bit st,
                                    output bit al, output ent_t e);
    int l;
    l      = int'(a[1:0]);
    st     = 1'b0;
    al     = 1'b1;
    e.addr = a & ~32'h3;
    e.wen  = 4'h0;
    e.data = 32'h0;
    if (op == OP_SB) begin
      st = 1'b1; e.wen = 4'(1 << l); e.data = {24'b0, w[7:0]} * 32'h01010101;
    end else if (op == OP_SH) begin
      st = 1'b1; al = (a % 2 == 0); e.wen = 4'(3 << l); e.data = {16'b0, w[15:0]} * 32'h00010001;
    end else if (op == OP_SW) begin
      st = 1'b1; al = (a % 4 == 0); e.wen = 4'hF; e.data = w;
    end
`ifdef STORE_SWLR_EN
    else if (op == OP_SWL) begin
      st = 1'b1; e.wen = 4'((2 << l) - 1); e.data = w >> (8 * (3 - l));
    end else if (op == OP_SWR) begin
      st = 1'b1; e.wen = 4'(15 << l); e.data = w << (8 * l);
    end
`endif
  endfunction

  task automatic check_outputs();
    int n;
    n = mq.size();
    check("in_ready", sb_if.in_ready, 64'(n < DEPTH));
    check("full", sb_if.full, 64'(n == DEPTH));
    check("empty", sb_if.empty, 64'(n == 0));
    check("count", sb_if.count, 64'(n));
    check("mem_en", sb_if.mem_en, 64'(n > 0));
    check("mem_wen", sb_if.mem_wen, n > 0 ? 64'(mq[0].wen) : 64'h0);
    check("mem_addr", sb_if.mem_addr, n > 0 ? 64'(mq[0].addr) : 64'h0);
    check("mem_wdata", sb_if.mem_wdata, n > 0 ? 64'(mq[0].data) : 64'h0);
    check("exc_ades", sb_if.exc_ades, 64'(m_exc));
    check("exc_badvaddr", sb_if.exc_badvaddr, 64'(m_bad));
  endtask

  // One clock: drive, check at negedge, advance the model at posedge.
  task automatic cycle(input bit v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] w, input bit mr, input bit r);
    bit   st, al, ready, pop, push, bad;
    ent_t e;
    sb_if.in_valid  = v;
    sb_if.in_op     = op;
    sb_if.in_addr   = a;
    sb_if.in_wdata  = w;
    sb_if.mem_ready = mr;
    rst             = r;
    @(negedge clk);
    check_outputs();
    model_enc(op, a, w, st, al, e);
    ready = mq.size() < DEPTH;
    pop   = (mq.size() > 0) && mr;
    push  = v && ready && st && al;
    bad   = v && ready && st && !al;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_exc = 1'b0;
      m_bad = 32'h0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      m_exc = bad;
      m_bad = bad ? a : 32'h0;
    end
    #1;
  endtask

  task automatic idle(input bit mr);
    cycle(1'b0, 6'h00, 32'h0, 32'h0, mr, 1'b0);
  endtask

  initial begin
    logic [5:0] ops [8];
    ops[0] = OP_SB;  ops[1] = OP_SH;  ops[2] = OP_SW;  ops[3] = OP_SWL;
    ops[4] = OP_SWR; ops[5] = 6'h23;  ops[6] = 6'h00;  ops[7] = 6'h2b;

    sb_if.in_valid  = 1'b0;
    sb_if.in_op     = 6'h0;
    sb_if.in_addr   = 32'h0;
    sb_if.in_wdata  = 32'h0;
    sb_if.mem_ready = 1'b0;
    rst             = 1'b1;
    m_exc           = 1'b0;
    m_bad           = 32'h0;
    @(posedge clk);
    #1;
    idle(1'b0);                       // checks post-reset state

    // SB into lane 3
    cycle(1'b1, OP_SB, 32'h1003, 32'h000000AB, 1'b1, 1'b0);
    check("sb_mem_en", sb_if.mem_en, 64'h1);
    check("sb_wen", sb_if.mem_wen, 64'h8);
    check("sb_wdata", sb_if.mem_wdata, 64'hABABABAB);
    check("sb_addr", sb_if.mem_addr, 64'h1000);
    idle(1'b1);

    // Misaligned SH
    cycle(1'b1, OP_SH, 32'h2001, 32'h1234, 1'b0, 1'b0);
    check("ades_pulse", sb_if.exc_ades, 64'h1);
    check("ades_addr", sb_if.exc_badvaddr, 64'h2001);
    check("ades_count", sb_if.count, 64'h0);
    check("ades_mem_en", sb_if.mem_en, 64'h0);
    idle(1'b0);

    // Fill, reject a fifth, drain in order
    for (int i = 0; i < 4; i++)
      cycle(1'b1, OP_SW, 32'h100 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 1'b0, 1'b0);
    check("fill_full", sb_if.full, 64'h1);
    check("fill_ready", sb_if.in_ready, 64'h0);
    cycle(1'b1, OP_SW, 32'h200, 32'hDEADBEEF, 1'b1, 1'b0);
    check("fifth_count", sb_if.count, 64'h3);
    check("fifth_head", sb_if.mem_addr, 64'h104);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("drain_empty", sb_if.empty, 64'h1);

    // Push and pop together at count 2
    cycle(1'b1, OP_SW, 32'h300, 32'h11111111, 1'b0, 1'b0);
    cycle(1'b1, OP_SW, 32'h304, 32'h22222222, 1'b0, 1'b0);
    cycle(1'b1, OP_SW, 32'h308, 32'h33333333, 1'b1, 1'b0);
    check("pp_count", sb_if.count, 64'h2);
    check("pp_head", sb_if.mem_addr, 64'h304);
    idle(1'b1);
    check("pp_next", sb_if.mem_wdata, 64'h33333333);
    idle(1'b1);

`ifdef STORE_SWLR_EN
    cycle(1'b1, OP_SWL, 32'h11, 32'hAABBCCDD, 1'b1, 1'b0);
    check("swl_wen", sb_if.mem_wen, 64'h3);
    check("swl_data", sb_if.mem_wdata[15:0], 64'hAABB);
    cycle(1'b1, OP_SWR, 32'h11, 32'hAABBCCDD, 1'b1, 1'b0);
    check("swr_wen", sb_if.mem_wen, 64'hE);
    check("swr_data", sb_if.mem_wdata[31:8], 64'hBBCCDD);
    idle(1'b1);
`else
    cycle(1'b1, OP_SWL, 32'h11, 32'hAABBCCDD, 1'b0, 1'b0);
    cycle(1'b1, OP_SWR, 32'h11, 32'hAABBCCDD, 1'b0, 1'b0);
    check("swlr_ignored", sb_if.count, 64'h0);
    check("swlr_noexc", sb_if.exc_ades, 64'h0);
`endif

    // Reset with three queued entries and mem_ready high
    for (int i = 0; i < 3; i++)
      cycle(1'b1, OP_SB, 32'h400 + 32'(i), 32'(i + 1), 1'b0, 1'b0);
    cycle(1'b0, 6'h00, 32'h0, 32'h0, 1'b1, 1'b1);
    check("rst_empty", sb_if.empty, 64'h1);
    check("rst_mem_en", sb_if.mem_en, 64'h0);
    check("rst_count", sb_if.count, 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  op;
      logic [31:0] a;
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) op = 6'($urandom);
      a  = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 3) != 0), op, a, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 79) == 0));
    end
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
